// File: rtl/csr_access_unit.sv
// CSR access unit: runs one CSR instruction at a time as read, read-modify-write, then response.
// Optional build macro CSR_ACCESS_ILLEGAL_TRAP_EN turns unmapped or read-only write accesses into rsp_illegal.
package pack;
    typedef enum logic [3:0] {
        CSR_MSTATUS   = 4'd0,
        CSR_MISA      = 4'd1,
        CSR_MIE       = 4'd2,
        CSR_MTVEC     = 4'd3,
        CSR_MSCRATCH  = 4'd4,
        CSR_MEPC      = 4'd5,
        CSR_MCAUSE    = 4'd6,
        CSR_MTVAL     = 4'd7,
        CSR_MIP       = 4'd8,
        CSR_MCYCLE    = 4'd9,
        CSR_MINSTRET  = 4'd10,
        CSR_MCYCLEH   = 4'd11,
        CSR_MINSTRETH = 4'd12
    } destinationCSR_;
endpackage

module csr_access_unit
    import pack::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_funct3,
    input  logic [11:0]    req_addr,
    input  logic [31:0]    req_rs1_data,
    input  logic [4:0]     req_rs1_idx,
    input  logic [4:0]     req_rd_idx,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_data,
    output logic [4:0]     rsp_rd_idx,
    output logic           rsp_illegal,
    output destinationCSR_ readCSR,
    input  logic [31:0]    csrReadData,
    output destinationCSR_ destinationCSR,
    output logic [31:0]    csrWriteData,
    output logic           csrDestinationEnable
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    destinationCSR_ idx_q, idx_d;
    logic           hit_q, hit_d;
    logic [1:0]     op_q, op_d;
    logic [31:0]    operand_q, operand_d;
    logic           write_q, write_d;
    logic           illegal_q, illegal_d;
    logic [4:0]     rd_q, rd_d;
    logic [31:0]    old_q, old_d;
    logic           we_q, we_d;
    destinationCSR_ dest_q, dest_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [4:0]     rsp_rd_q, rsp_rd_d;
    logic           rsp_illegal_q, rsp_illegal_d;

    destinationCSR_ dec_idx;
    logic           dec_hit;
    logic [31:0]    acc_operand;
    logic           acc_legal, acc_attempt, acc_ro, acc_illegal, acc_write;
    logic [31:0]    rmw_value;

    always_comb begin
        dec_idx = CSR_MSTATUS;
        dec_hit = 1'b1;
        case (req_addr)
            12'h300: dec_idx = CSR_MSTATUS;
            12'h301: dec_idx = CSR_MISA;
            12'h304: dec_idx = CSR_MIE;
            12'h305: dec_idx = CSR_MTVEC;
            12'h340: dec_idx = CSR_MSCRATCH;
            12'h341: dec_idx = CSR_MEPC;
            12'h342: dec_idx = CSR_MCAUSE;
            12'h343: dec_idx = CSR_MTVAL;
            12'h344: dec_idx = CSR_MIP;
            12'hB00: dec_idx = CSR_MCYCLE;
            12'hB02: dec_idx = CSR_MINSTRET;
            12'hB80: dec_idx = CSR_MCYCLEH;
            12'hB82: dec_idx = CSR_MINSTRETH;
            default: dec_hit = 1'b0;
        endcase
    end

    // Everything about whether the access writes or traps is known at accept time.
    assign acc_operand = req_funct3[2] ? {27'b0, req_rs1_idx} : req_rs1_data;
    assign acc_legal   = (req_funct3[1:0] != 2'b00);
    assign acc_attempt = acc_legal && !((req_funct3[1:0] != 2'b01) && (req_rs1_idx == 5'd0));
    assign acc_ro      = (req_addr == 12'h301) || (req_addr[11:10] == 2'b11);
`ifdef CSR_ACCESS_ILLEGAL_TRAP_EN
    assign acc_illegal = !acc_legal || !dec_hit || (acc_attempt && acc_ro);
`else
    assign acc_illegal = !acc_legal;
`endif
    assign acc_write   = acc_attempt && dec_hit && !acc_ro && !acc_illegal;

    always_comb begin
        case (op_q)
            2'b01:   rmw_value = operand_q;
            2'b10:   rmw_value = csrReadData | operand_q;
            default: rmw_value = csrReadData & ~operand_q;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q value so no branch leaves it unassigned and infers a latch.
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        op_d          = op_q;
        operand_d     = operand_q;
        write_d       = write_q;
        illegal_d     = illegal_q;
        rd_d          = rd_q;
        old_d         = old_q;
        we_d          = we_q;
        dest_d        = dest_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_READ;
                    req_ready_d = 1'b0;
                    idx_d       = dec_idx;
                    hit_d       = dec_hit;
                    op_d        = req_funct3[1:0];
                    operand_d   = acc_operand;
                    write_d     = acc_write;
                    illegal_d   = acc_illegal;
                    rd_d        = req_rd_idx;
                end
            end
            S_READ: begin
                state_d = S_WRITE;
                old_d   = hit_q ? csrReadData : 32'd0;
                we_d    = write_q;
                if (write_q) begin
                    dest_d  = idx_q;
                    wdata_d = rmw_value;
                end
            end
            S_WRITE: begin
                state_d       = S_RESP;
                we_d          = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_data_d    = illegal_q ? 32'd0 : old_q;
                rsp_rd_d      = rd_q;
                rsp_illegal_d = illegal_q;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            idx_q         <= CSR_MSTATUS;
            hit_q         <= 1'b0;
            op_q          <= 2'b00;
            operand_q     <= 32'd0;
            write_q       <= 1'b0;
            illegal_q     <= 1'b0;
            rd_q          <= 5'd0;
            old_q         <= 32'd0;
            we_q          <= 1'b0;
            dest_q        <= CSR_MSTATUS;
            wdata_q       <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_rd_q      <= 5'd0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            idx_q         <= idx_d;
            hit_q         <= hit_d;
            op_q          <= op_d;
            operand_q     <= operand_d;
            write_q       <= write_d;
            illegal_q     <= illegal_d;
            rd_q          <= rd_d;
            old_q         <= old_d;
            we_q          <= we_d;
            dest_q        <= dest_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Gating with reset keeps a strobe or response from escaping in the very cycle reset arrives.
    assign csrDestinationEnable = we_q && !reset;
    assign rsp_valid            = rsp_valid_q && !reset;
    assign req_ready            = req_ready_q;
    assign readCSR              = idx_q;
    assign destinationCSR       = dest_q;
    assign csrWriteData         = wdata_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_rd_idx           = rsp_rd_q;
    assign rsp_illegal          = rsp_illegal_q;

endmodule
